// File: rtl/output_ports.sv
// Output pin block: registered level writes and timed pulses on pins D0..D3.
// Optional macro OUTPORT_TOGGLE_EN adds a toggle input that inverts the selected pin.
module output_ports #(
    parameter int unsigned PULSE_CYCLES = 4,
    parameter logic [3:0]  RESET_VAL    = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [1:0] pin_sel,
    input  logic       pin_val,
    input  logic       pulse,
`ifdef OUTPORT_TOGGLE_EN
    input  logic       toggle,
`endif
    output logic       D0,
    output logic       D1,
    output logic       D2,
    output logic       D3,
    output logic       busy,
    output logic       ack
);

    localparam int unsigned CntW = $clog2(PULSE_CYCLES + 1);
    localparam logic [CntW-1:0] CntInit = CntW'(PULSE_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StPulse} state_t;

    state_t          state;
    logic [3:0]      pins;
    logic [CntW-1:0] cnt;
    logic            saved_val;
    logic [1:0]      saved_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            pins      <= RESET_VAL;
            cnt       <= '0;
            saved_val <= 1'b0;
            saved_sel <= 2'd0;
            busy      <= 1'b0;
            ack       <= 1'b0;
        end else begin
            ack <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (wr_en) begin
`ifdef OUTPORT_TOGGLE_EN
                        if (toggle) begin
                            pins[pin_sel] <= ~pins[pin_sel];
                            ack           <= 1'b1;
                        end else
`endif
                        if (pulse) begin
                            saved_val     <= pins[pin_sel];
                            saved_sel     <= pin_sel;
                            pins[pin_sel] <= pin_val;
                            cnt           <= CntInit;
                            busy          <= 1'b1;
                            state         <= StPulse;
                        end else begin
                            pins[pin_sel] <= pin_val;
                            ack           <= 1'b1;
                        end
                    end
                end
                StPulse: begin
                    // Commands are dropped for the whole pulse, including the restoring edge.
                    if (cnt != '0) begin
                        cnt <= cnt - CntW'(1);
                    end else begin
                        pins[saved_sel] <= saved_val;
                        busy            <= 1'b0;
                        ack             <= 1'b1;
                        state           <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign D0 = pins[0];
    assign D1 = pins[1];
    assign D2 = pins[2];
    assign D3 = pins[3];

endmodule

// File: tb/tb_output_ports.sv
// Directed bench for output_ports; four instances cover different parameter sets.
module tb_output_ports;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] pin_sel = 2'd0;
    logic       pin_val = 1'b0;
    logic       pulse = 1'b0;
`ifdef OUTPORT_TOGGLE_EN
    logic       toggle = 1'b0;
`endif

    logic [3:0] a_d, b_d, c_d, d_d;
    logic       a_busy, b_busy, c_busy, d_busy;
    logic       a_ack, b_ack, c_ack, d_ack;
    logic [5:0] obs_a, obs_b, obs_c, obs_d;

    int checks = 0;
    int errors = 0;

    assign obs_a = {a_d, a_busy, a_ack};
    assign obs_b = {b_d, b_busy, b_ack};
    assign obs_c = {c_d, c_busy, c_ack};
    assign obs_d = {d_d, d_busy, d_ack};

    always #5 clk = ~clk;

    output_ports #(.PULSE_CYCLES(4), .RESET_VAL(4'b0000)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .pin_sel(pin_sel), .pin_val(pin_val),
        .pulse(pulse),
`ifdef OUTPORT_TOGGLE_EN
        .toggle(toggle),
`endif
        .D0(a_d[0]), .D1(a_d[1]), .D2(a_d[2]), .D3(a_d[3]), .busy(a_busy), .ack(a_ack));

    output_ports #(.PULSE_CYCLES(4), .RESET_VAL(4'b1010)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .pin_sel(pin_sel), .pin_val(pin_val),
        .pulse(pulse),
`ifdef OUTPORT_TOGGLE_EN
        .toggle(toggle),
`endif
        .D0(b_d[0]), .D1(b_d[1]), .D2(b_d[2]), .D3(b_d[3]), .busy(b_busy), .ack(b_ack));

    output_ports #(.PULSE_CYCLES(4), .RESET_VAL(4'b0001)) dut_c (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .pin_sel(pin_sel), .pin_val(pin_val),
        .pulse(pulse),
`ifdef OUTPORT_TOGGLE_EN
        .toggle(toggle),
`endif
        .D0(c_d[0]), .D1(c_d[1]), .D2(c_d[2]), .D3(c_d[3]), .busy(c_busy), .ack(c_ack));

    output_ports #(.PULSE_CYCLES(1), .RESET_VAL(4'b0000)) dut_d (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .pin_sel(pin_sel), .pin_val(pin_val),
        .pulse(pulse),
`ifdef OUTPORT_TOGGLE_EN
        .toggle(toggle),
`endif
        .D0(d_d[0]), .D1(d_d[1]), .D2(d_d[2]), .D3(d_d[3]), .busy(d_busy), .ack(d_ack));

    // Advance past the next rising edge; inputs and samples sit 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr_en = 1'b0;
        pulse = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic set_cmd(input logic en, input logic [1:0] sel, input logic val,
                           input logic pls);
        wr_en   = en;
        pin_sel = sel;
        pin_val = val;
        pulse   = pls;
    endtask

    task automatic test_reset();
        wr_en = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++;
        if (obs_a !== 6'b0000_00) begin
            errors++; $display("FAIL reset_a got %b want %b", obs_a, 6'b0000_00);
        end
        checks++;
        if (obs_b !== 6'b1010_00) begin
            errors++; $display("FAIL reset_b got %b want %b", obs_b, 6'b1010_00);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs_a !== 6'b0000_00) begin
            errors++; $display("FAIL reset_release_a got %b want %b", obs_a, 6'b0000_00);
        end
        checks++;
        if (obs_b !== 6'b1010_00) begin
            errors++; $display("FAIL reset_release_b got %b want %b", obs_b, 6'b1010_00);
        end
    endtask

    task automatic test_level();
        do_reset();
        set_cmd(1'b1, 2'd2, 1'b1, 1'b0);
        tick();
        checks++;
        if (obs_a !== 6'b0100_01) begin
            errors++; $display("FAIL level_set got %b want %b", obs_a, 6'b0100_01);
        end
        set_cmd(1'b1, 2'd2, 1'b0, 1'b0);
        tick();
        checks++;
        if (obs_a !== 6'b0000_01) begin
            errors++; $display("FAIL level_clear got %b want %b", obs_a, 6'b0000_01);
        end
        tick();
        checks++;
        if (obs_a !== 6'b0000_01) begin
            errors++; $display("FAIL level_same_value got %b want %b", obs_a, 6'b0000_01);
        end
        set_cmd(1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if (obs_a !== 6'b0000_00) begin
            errors++; $display("FAIL level_idle got %b want %b", obs_a, 6'b0000_00);
        end
    endtask

    task automatic test_pulse();
        do_reset();
        set_cmd(1'b1, 2'd1, 1'b1, 1'b1);
        tick(); // T0
        checks++;
        if (obs_a !== 6'b0010_10) begin
            errors++; $display("FAIL pulse_t0 got %b want %b", obs_a, 6'b0010_10);
        end
        set_cmd(1'b0, 2'd3, 1'b1, 1'b0);
        tick(); // T1
        set_cmd(1'b1, 2'd3, 1'b1, 1'b0);
        tick(); // T2, write ignored
        checks++;
        if (obs_a !== 6'b0010_10) begin
            errors++; $display("FAIL pulse_t2_ignored got %b want %b", obs_a, 6'b0010_10);
        end
        set_cmd(1'b0, 2'd3, 1'b1, 1'b0);
        tick(); // T3
        checks++;
        if (obs_a !== 6'b0010_10) begin
            errors++; $display("FAIL pulse_t3 got %b want %b", obs_a, 6'b0010_10);
        end
        set_cmd(1'b1, 2'd3, 1'b1, 1'b0);
        tick(); // T4: restore, command dropped
        checks++;
        if (obs_a !== 6'b0000_01) begin
            errors++; $display("FAIL pulse_t4_restore got %b want %b", obs_a, 6'b0000_01);
        end
        tick(); // T5: accepted
        checks++;
        if (obs_a !== 6'b1000_01) begin
            errors++; $display("FAIL pulse_t5_write got %b want %b", obs_a, 6'b1000_01);
        end
        set_cmd(1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if (obs_a !== 6'b1000_00) begin
            errors++; $display("FAIL pulse_after got %b want %b", obs_a, 6'b1000_00);
        end
    endtask

    task automatic test_pulse_same_level();
        do_reset();
        set_cmd(1'b1, 2'd1, 1'b0, 1'b1);
        tick();
        set_cmd(1'b0, 2'd0, 1'b0, 1'b0);
        checks++;
        if (obs_a !== 6'b0000_10) begin
            errors++; $display("FAIL same_level_t0 got %b want %b", obs_a, 6'b0000_10);
        end
        tick(); tick(); tick();
        checks++;
        if (obs_a !== 6'b0000_10) begin
            errors++; $display("FAIL same_level_t3 got %b want %b", obs_a, 6'b0000_10);
        end
        tick();
        checks++;
        if (obs_a !== 6'b0000_01) begin
            errors++; $display("FAIL same_level_t4 got %b want %b", obs_a, 6'b0000_01);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_cmd(1'b1, 2'd0, 1'b0, 1'b1);
        tick(); // T0
        set_cmd(1'b0, 2'd0, 1'b0, 1'b0);
        checks++;
        if (obs_c !== 6'b0000_10) begin
            errors++; $display("FAIL async_pulse_t0 got %b want %b", obs_c, 6'b0000_10);
        end
        tick(); tick(); // T2
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs_c !== 6'b0001_00) begin
            errors++; $display("FAIL async_reset_now got %b want %b", obs_c, 6'b0001_00);
        end
        #1;
        rst_n = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (obs_c !== 6'b0001_00) begin
            errors++; $display("FAIL async_after_release got %b want %b", obs_c, 6'b0001_00);
        end
    endtask

    task automatic test_pulse_one();
        do_reset();
        set_cmd(1'b1, 2'd3, 1'b1, 1'b1);
        tick(); // T0
        set_cmd(1'b0, 2'd0, 1'b0, 1'b0);
        checks++;
        if (obs_d !== 6'b1000_10) begin
            errors++; $display("FAIL one_t0 got %b want %b", obs_d, 6'b1000_10);
        end
        tick(); // T1
        checks++;
        if (obs_d !== 6'b0000_01) begin
            errors++; $display("FAIL one_t1 got %b want %b", obs_d, 6'b0000_01);
        end
        tick();
        checks++;
        if (obs_d !== 6'b0000_00) begin
            errors++; $display("FAIL one_t2 got %b want %b", obs_d, 6'b0000_00);
        end
    endtask

`ifdef OUTPORT_TOGGLE_EN
    task automatic test_toggle();
        do_reset();
        set_cmd(1'b1, 2'd0, 1'b0, 1'b1);
        toggle = 1'b1;
        tick();
        checks++;
        if (obs_a !== 6'b0001_01) begin
            errors++; $display("FAIL toggle_first got %b want %b", obs_a, 6'b0001_01);
        end
        tick();
        checks++;
        if (obs_a !== 6'b0000_01) begin
            errors++; $display("FAIL toggle_second got %b want %b", obs_a, 6'b0000_01);
        end
        toggle = 1'b0;
        set_cmd(1'b0, 2'd0, 1'b0, 1'b0);
        tick();
    endtask
`endif

    initial begin
        #2;
        test_reset();
        test_level();
        test_pulse();
        test_pulse_same_level();
        test_async_reset();
        test_pulse_one();
`ifdef OUTPORT_TOGGLE_EN
        test_toggle();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
